fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and drives the instruction-memory address; instruction memory is combinational.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to IF/ID with a valid/ready handshake.
- Redirects and flushes on a taken branch from the MEM stage, so IF/ID stalls (PCWrite low) no longer lose fetched instructions.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, fetch PC after reset.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  fetch enable; no new fetches while low.
- imem_addr_o  out  32  instruction-memory address, equal to the fetch PC.
- imem_instr_i  in  32  instruction at imem_addr_o, same cycle.
- redirect_i  in  1  taken branch (PCSrc from the MEM stage).
- redirect_pc_i  in  32  branch target.
- ready_i  in  1  IF/ID accepts this cycle (PCWrite).
- valid_o  out  1  head entry valid.
- pc_o  out  32  head entry PC.
- instr_o  out  32  head entry instruction.
- count_o  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async): fetch_pc=RESET_PC, wr_ptr=rd_ptr=0, count=0, valid_o=0, pc_o=0, instr_o=NOP (32'h0000_0013), count_o=0.
- Outputs:
  - imem_addr_o = fetch_pc, combinationally.
  - When empty: valid_o=0, pc_o=0, instr_o=NOP.
  - When not empty: the head entry is driven combinationally from the storage array.
- pop = valid_o & ready_i & ~redirect_i.
- push = start_i & ~redirect_i & (count<DEPTH | pop).
  - A push when full is allowed only when a pop happens in the same cycle.
- On push:
  - Entry {fetch_pc, imem_instr_i} is written at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
- On pop: rd_ptr increments modulo DEPTH.
- count changes by +1 on push only, -1 on pop only, and is unchanged on both or neither.
- Latency:
  - An instruction fetched in cycle N is visible at valid_o in cycle N+1.
  - No empty-queue bypass.
- Redirect has priority over everything in that cycle:
  - Queue cleared: count=0, pointers reset to 0.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - No push and no pop.
  - valid_o=0 in the following cycle.
  - The first post-redirect instruction is presented two cycles after the redirect cycle.
- start_i low: fetch_pc holds; pops continue, so the queue drains.
- ready_i low with the queue full: no push and fetch_pc holds; head outputs stay stable until accepted.
- ready_i is ignored while valid_o=0.
- Reset asserted mid-operation discards all entries immediately, regardless of the clock.

Optional Feature:
- Macro: FETCH_QUEUE_STATS_EN.
- Defined:
  - Adds output fetch_cnt_o (32 bits), incremented on each push.
  - Adds output flush_cnt_o (32 bits), incremented by count on each redirect, i.e. entries discarded.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: neither counter nor either port exists; remaining behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_LEN=4.
  - NOP_INSTR=32'h0000_0013.
  - DEFAULT_RESET_PC.
  - A fetch_entry_t struct {pc[31:0], instr[31:0]}.
- One sub-module: fetch_fifo.
  - Generic DEPTH-entry FIFO of fetch_entry_t with push, pop, clear, full, empty and count.
  - fetch_queue adds the fetch-PC register, the push/pop/redirect priority and the optional counters.

Test Plan:
1. Reset with RESET_PC=0, then start_i=1 and ready_i=1 -> imem_addr_o=0,4,8 in successive cycles; valid_o first high one cycle after start; pc_o=0,4,8 in sequence with matching instr_o.
2. ready_i=0 for 6 cycles with start_i=1 -> count_o reaches 4, valid_o stays high, fetch_pc holds at 16; release ready_i -> pc_o 0,4,8,12,16 consecutively with no gaps or duplicates.
3. Queue holds 3 entries and redirect_i=1 with redirect_pc_i=32'h40 -> next cycle valid_o=0 and count_o=0; the following cycle pc_o=32'h40.
4. redirect_i=1 and ready_i=1 in the same cycle with the queue full -> no pop is observed, queue empties, fetch_pc=redirect target; redirect_pc_i=32'h43 -> fetch resumes at 32'h40.
5. Full queue with ready_i=1 and start_i=1 -> a push and a pop occur every cycle, count_o stays 4, throughput is 1 per cycle; pointer wrap is exercised for more than 2*DEPTH cycles.
6. With FETCH_QUEUE_STATS_EN: 10 pushes, then a redirect with 3 queued -> fetch_cnt_o=10, flush_cnt_o=3; rst_i pulsed mid-clock -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction length, NOP encoding,
// default reset PC, the fetch-queue entry type and a saturating adder.
package cpu_pkg;

    localparam int          INSTR_LEN        = 4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Unsigned 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// IF/ID handshake bundle between the fetch queue and the IF/ID register.
// Handshake: an entry transfers in a cycle where valid_o and ready_i are both
// high; while valid_o is high and ready_i is low, pc_o/instr_o hold steady.
// ready_i is don't-care while valid_o is low.
interface fetch_queue_if;

    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;

    // Fetch side: produces entries.
    modport master (
        output valid_o,
        output pc_o,
        output instr_o,
        input  ready_i
    );

    // IF/ID side: consumes entries.
    modport slave (
        input  valid_o,
        input  pc_o,
        input  instr_o,
        output ready_i
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Generic DEPTH-entry FIFO of fetch_entry_t with synchronous clear.
// Clear wins over push/pop. Push while full is only honoured together with a pop.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o & ~clear_i;
    assign push_ok = push_i & ~clear_i & (~full_o | pop_ok);

    // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and count registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed through a non-empty head.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the combinational
// instruction memory, buffers {pc, instr} pairs in fetch_fifo and hands them
// to IF/ID. A taken branch (redirect_i) flushes the queue and retargets fetch.
// Optional build macro FETCH_QUEUE_STATS_EN adds fetch_cnt_o / flush_cnt_o.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    localparam int          CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    fetch_queue_if.master    ifid,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [31:0]      fetch_cnt_o,
    output logic [31:0]      flush_cnt_o,
`endif
    output logic [CNT_W-1:0] count_o
);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             push, pop;
    logic             full, empty;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;
    fetch_entry_t     wentry;
    logic             unused_pc_bits;

    // Branch targets are forced word-aligned, so the low bits are dropped.
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Redirect suppresses both queue operations; a full queue accepts a push
    // only when the head leaves in the same cycle.
    assign pop  = ~empty & ifid.ready_i & ~redirect_i;
    assign push = start_i & ~redirect_i & (~full | pop);

    assign wentry.pc    = fetch_pc_q;
    assign wentry.instr = imem_instr_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (redirect_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wentry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign imem_addr_o = fetch_pc_q;
    assign count_o     = count;

    // Head presentation: NOP at PC 0 whenever nothing is queued.
    always_comb begin
        ifid.valid_o = 1'b0;
        ifid.pc_o    = 32'h0;
        ifid.instr_o = NOP_INSTR;
        if (!empty) begin
            ifid.valid_o = 1'b1;
            ifid.pc_o    = head.pc;
            ifid.instr_o = head.instr;
        end
    end

    // Next fetch PC: redirect target wins, otherwise advance on each push.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'(INSTR_LEN);
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Statistics: pushes seen and entries thrown away by redirects, saturating.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (push) begin
            fetch_cnt_d = sat_add32(fetch_cnt_q, 32'd1);
        end
        if (redirect_i) begin
            flush_cnt_d = sat_add32(flush_cnt_q, 32'(count));
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt_q <= 32'h0;
            flush_cnt_q <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
